// File: rtl/rfile_wb_arbiter.sv
// rfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   requesters (A = ALU, B = load) with a 1-bit round-robin pointer, and keeps
//   a pending-write scoreboard that issue logic queries through the two
//   register-file read addresses.
//
// Optional feature (macro RFILE_WB_FWD_EN):
//   When defined, each read port reports a forwarding hit whenever the write
//   currently on the write port targets the register being read. The hit
//   covers the wr_en cycle, in which busy is still set. When undefined, the
//   fwd_* outputs are tied to 0 and the ports remain.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   a_req/a_reg/a_data/a_gnt   requester A (ALU); gnt is combinational
//   b_req/b_reg/b_data/b_gnt   requester B (load); gnt is combinational
//   wr_en/wr_reg/wr_data       registered register-file write port
//   rsv_en/rsv_reg             issue reserves a destination register
//   read_reg_1/read_reg_2      addresses on the register-file read ports
//   busy_1/busy_2              queried register has a pending write
//   fwd_hit_1/fwd_hit_2        forwarding hit on the queried register
//   fwd_data_1/fwd_data_2      forwarded data (0 when no hit)

// Per-read-port query: busy lookup plus optional forwarding compare.
module rfile_wb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [(2**ADDR_W)-1:0] pending,
  input  logic [ADDR_W-1:0]      read_reg,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_reg,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data
);

  assign busy = pending[read_reg];

`ifdef RFILE_WB_FWD_EN
  // Register 0 never produces a write, but guard it anyway so a stale
  // wr_reg of 0 can never look like a hit.
  assign fwd_hit  = wr_en && (wr_reg == read_reg) && (wr_reg != '0);
  assign fwd_data = fwd_hit ? wr_data : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{wr_en, wr_reg, wr_data};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

module rfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NUM_RD   = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  wb_req_t req_a, req_b, req_win, wb_q;

  logic                last_b;    // 1: B was granted last, so A wins a conflict
  logic                a_win, b_win, any_gnt;
  logic                wb_vld;    // granted write that will reach the port
  logic                wr_vld_q;
  logic [NUM_REGS-1:0] pending, pend_set, pend_clr;

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]             busy_v, hit_v;
  logic [NUM_RD-1:0][DATA_W-1:0] fdata_v;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign req_a = '{rd: a_reg, data: a_data};
  assign req_b = '{rd: b_reg, data: b_data};

  assign a_win   = a_req && (!b_req || last_b);
  assign b_win   = b_req && !a_win;
  // Grants are held off during reset so no transfer is ever seen then.
  assign a_gnt   = rst_n && a_win;
  assign b_gnt   = rst_n && b_win;
  assign any_gnt = a_gnt || b_gnt;

  assign req_win = a_win ? req_a : req_b;
  // Writes to register 0 are accepted but dropped here.
  assign wb_vld  = any_gnt && (req_win.rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (any_gnt) begin
      last_b <= b_gnt;
    end
  end

  // ---------------------------------------------------------------------
  // Write port register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_q <= 1'b0;
      wb_q     <= '0;
    end else begin
      wr_vld_q <= wb_vld;
      if (wb_vld) wb_q <= req_win;
    end
  end

  assign wr_en   = wr_vld_q;
  assign wr_reg  = wb_q.rd;
  assign wr_data = wb_q.data;

  // ---------------------------------------------------------------------
  // Pending-write scoreboard. A reservation landing on the same edge as the
  // retiring write to that register belongs to a newer instruction, so the
  // set is applied after the clear.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (rsv_en && (rsv_reg != '0)) pend_set[rsv_reg] = 1'b1;
    if (wr_en)                     pend_clr[wr_reg]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;
    end
  end

  // ---------------------------------------------------------------------
  // Read-port queries
  // ---------------------------------------------------------------------
  assign rd_addr = {read_reg_2, read_reg_1};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    rfile_wb_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .pending  (pending),
      .read_reg (rd_addr[g]),
      .wr_en    (wr_en),
      .wr_reg   (wr_reg),
      .wr_data  (wr_data),
      .busy     (busy_v[g]),
      .fwd_hit  (hit_v[g]),
      .fwd_data (fdata_v[g])
    );
  end

  assign busy_1     = busy_v[0];
  assign busy_2     = busy_v[1];
  assign fwd_hit_1  = hit_v[0];
  assign fwd_hit_2  = hit_v[1];
  assign fwd_data_1 = fdata_v[0];
  assign fwd_data_2 = fdata_v[1];

endmodule

// File: tb/tb_rfile_wb_arbiter.sv
module tb_rfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, b_req, a_gnt, b_gnt;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_reg, read_reg_1, read_reg_2;
  logic          busy_1, busy_2, fwd_hit_1, fwd_hit_2;
  logic [DW-1:0] fwd_data_1, fwd_data_2;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef RFILE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  rfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_reg(a_reg), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_reg(b_reg), .b_data(b_data), .b_gnt(b_gnt),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
  );

  task automatic idle();
    a_req = 0; a_reg = 0; a_data = 0;
    b_req = 0; b_reg = 0; b_data = 0;
    rsv_en = 0; rsv_reg = 0;
    read_reg_1 = 0; read_reg_2 = 0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    a_req = 1; a_reg = 4; b_req = 1; b_reg = 6;
    @(posedge clk); #1;
    n_chk++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_fail++;
      $display("FAIL reset_gnt: got a=%b b=%b need 0 0", a_gnt, b_gnt); end
    n_chk++; if (wr_en !== 1'b0 || wr_reg !== '0 || wr_data !== '0) begin n_fail++;
      $display("FAIL reset_wr: got en=%b reg=%0d data=%h need 0 0 0", wr_en, wr_reg, wr_data); end
    for (int r = 0; r < 32; r++) begin
      read_reg_1 = r[AW-1:0]; read_reg_2 = r[AW-1:0]; #1;
      n_chk++; if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin n_fail++;
        $display("FAIL reset_busy: reg %0d got %b %b need 0", r, busy_1, busy_2); end
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single_write();
    do_reset();
    a_req = 1; a_reg = 5; a_data = 32'hDEADBEEF; #1;
    n_chk++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_fail++;
      $display("FAIL single_gnt: got a=%b b=%b need 1 0", a_gnt, b_gnt); end
    step(); a_req = 0;
    n_chk++; if (wr_en !== 1'b1 || wr_reg !== 5 || wr_data !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL single_wr: got en=%b reg=%0d data=%h need 1 5 deadbeef", wr_en, wr_reg, wr_data); end
    step();
    n_chk++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL single_wr_off: got %b need 0", wr_en); end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] exp_reg;
    do_reset();
    a_req = 1; b_req = 1;
    a_reg = 10; a_data = 32'hA0; b_reg = 20; b_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin n_fail++;
        $display("FAIL alt_gnt%0d: got a=%b b=%b need a=%b", i, a_gnt, b_gnt, (i % 2 == 0)); end
      exp_reg = (i % 2 == 0) ? a_reg : b_reg;
      step();
      n_chk++; if (wr_en !== 1'b1 || wr_reg !== exp_reg) begin n_fail++;
        $display("FAIL alt_wr%0d: got en=%b reg=%0d need 1 %0d", i, wr_en, wr_reg, exp_reg); end
      // The granted requester presents its next write.
      if (i % 2 == 0) begin a_reg = a_reg + 1; a_data = a_data + 1; end
      else            begin b_reg = b_reg + 1; b_data = b_data + 1; end
    end
    idle();
  endtask

  task automatic test_busy();
    do_reset();
    rsv_en = 1; rsv_reg = 7; read_reg_1 = 7; #1;
    n_chk++; if (busy_1 !== 1'b0) begin n_fail++;
      $display("FAIL busy_pre: got %b need 0", busy_1); end
    step(); rsv_en = 0; #1;
    n_chk++; if (busy_1 !== 1'b1) begin n_fail++;
      $display("FAIL busy_rsv: got %b need 1", busy_1); end
    step();
    a_req = 1; a_reg = 7; a_data = 32'h77; #1;
    n_chk++; if (busy_1 !== 1'b1 || a_gnt !== 1'b1) begin n_fail++;
      $display("FAIL busy_gnt: got busy=%b gnt=%b need 1 1", busy_1, a_gnt); end
    step(); a_req = 0; #1;
    n_chk++; if (busy_1 !== 1'b1 || wr_en !== 1'b1) begin n_fail++;
      $display("FAIL busy_wr: got busy=%b en=%b need 1 1", busy_1, wr_en); end
    step();
    n_chk++; if (busy_1 !== 1'b0) begin n_fail++;
      $display("FAIL busy_clear: got %b need 0", busy_1); end
  endtask

  task automatic test_reg0();
    do_reset();
    a_req = 1; a_reg = 0; a_data = 32'hFFFFFFFF; read_reg_1 = 0;
    rsv_en = 1; rsv_reg = 0; #1;
    n_chk++; if (a_gnt !== 1'b1) begin n_fail++;
      $display("FAIL reg0_gnt: got %b need 1", a_gnt); end
    step(); a_req = 0; rsv_en = 0;
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (wr_en !== 1'b0 || busy_1 !== 1'b0) begin n_fail++;
        $display("FAIL reg0_wr%0d: got en=%b busy=%b need 0 0", i, wr_en, busy_1); end
      step();
    end
  endtask

  task automatic test_set_clear_same();
    do_reset();
    rsv_en = 1; rsv_reg = 9;
    step(); rsv_en = 0;
    a_req = 1; a_reg = 9; a_data = 32'h99;
    step(); a_req = 0;
    rsv_en = 1; rsv_reg = 9; read_reg_2 = 9; #1;
    n_chk++; if (wr_en !== 1'b1 || wr_reg !== 9) begin n_fail++;
      $display("FAIL same_wr: got en=%b reg=%0d need 1 9", wr_en, wr_reg); end
    step(); rsv_en = 0; #1;
    n_chk++; if (busy_2 !== 1'b1) begin n_fail++;
      $display("FAIL same_edge_set: got %b need 1", busy_2); end
  endtask

  task automatic test_forward();
    do_reset();
    a_req = 1; a_reg = 3; a_data = 32'h1234; read_reg_2 = 3; read_reg_1 = 4; #1;
    n_chk++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== '0) begin n_fail++;
      $display("FAIL fwd_pre: got %b %h need 0 0", fwd_hit_2, fwd_data_2); end
    step(); a_req = 0; #1;
    n_chk++; if (fwd_hit_2 !== FWD || fwd_data_2 !== (FWD ? 32'h1234 : 32'h0)) begin n_fail++;
      $display("FAIL fwd_hit: got %b %h need %b %h", fwd_hit_2, fwd_data_2, FWD, FWD ? 32'h1234 : 32'h0); end
    n_chk++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== '0) begin n_fail++;
      $display("FAIL fwd_other: got %b %h need 0 0", fwd_hit_1, fwd_data_1); end
    step();
    n_chk++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== '0) begin n_fail++;
      $display("FAIL fwd_post: got %b %h need 0 0", fwd_hit_2, fwd_data_2); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    rsv_en = 1; rsv_reg = 12;
    step(); rsv_en = 0;
    a_req = 1; a_reg = 12; a_data = 32'hC0FFEE;
    step();
    // Write is registered; reset before it retires.
    rst_n = 0; #1;
    n_chk++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL mid_wr_en: got %b need 0", wr_en); end
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      read_reg_1 = r[AW-1:0]; #1;
      if (busy_1 !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++;
      $display("FAIL mid_sb: got %0d busy regs need 0", bad); end
    idle();
    @(posedge clk); #1; rst_n = 1;
    step();
    n_chk++; if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL mid_after: got %b need 0", wr_en); end
  endtask

  task automatic test_random();
    bit            pend [32];
    bit            m_last_b, m_wr_en, ea, eb, e_hit1, e_hit2;
    logic [AW-1:0] m_wr_reg, w_reg;
    logic [DW-1:0] m_wr_data, w_data;
    do_reset();
    foreach (pend[i]) pend[i] = 0;
    m_last_b = 1; m_wr_en = 0; m_wr_reg = 0; m_wr_data = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Requesters only change after a transfer (or when idle).
      if (!a_req) begin
        a_req = ($urandom_range(0, 9) < 6);
        a_reg = AW'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!b_req) begin
        b_req = ($urandom_range(0, 9) < 6);
        b_reg = AW'($urandom_range(0, 31)); b_data = $urandom;
      end
      rsv_en  = ($urandom_range(0, 9) < 3);
      rsv_reg = AW'($urandom_range(0, 31));
      read_reg_1 = $urandom_range(0, 1) ? m_wr_reg : AW'($urandom_range(0, 31));
      read_reg_2 = AW'($urandom_range(0, 31));
      #1;
      ea = a_req && (!b_req || m_last_b);
      eb = b_req && !ea;
      n_chk++; if (a_gnt !== ea || b_gnt !== eb) begin n_fail++;
        $display("FAIL rnd_gnt c%0d: got a=%b b=%b need a=%b b=%b", cyc, a_gnt, b_gnt, ea, eb); end
      n_chk++; if (wr_en !== m_wr_en || (m_wr_en && (wr_reg !== m_wr_reg || wr_data !== m_wr_data))) begin n_fail++;
        $display("FAIL rnd_wr c%0d: got %b %0d %h need %b %0d %h", cyc, wr_en, wr_reg, wr_data, m_wr_en, m_wr_reg, m_wr_data); end
      n_chk++; if (busy_1 !== pend[read_reg_1] || busy_2 !== pend[read_reg_2]) begin n_fail++;
        $display("FAIL rnd_busy c%0d: got %b %b need %b %b", cyc, busy_1, busy_2, pend[read_reg_1], pend[read_reg_2]); end
      e_hit1 = FWD && m_wr_en && m_wr_reg == read_reg_1 && m_wr_reg != 0;
      e_hit2 = FWD && m_wr_en && m_wr_reg == read_reg_2 && m_wr_reg != 0;
      n_chk++; if (fwd_hit_1 !== e_hit1 || fwd_hit_2 !== e_hit2 ||
                   fwd_data_1 !== (e_hit1 ? m_wr_data : 32'h0) ||
                   fwd_data_2 !== (e_hit2 ? m_wr_data : 32'h0)) begin n_fail++;
        $display("FAIL rnd_fwd c%0d: got %b %b %h %h need %b %b", cyc, fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, e_hit1, e_hit2); end
      // Advance the model across the edge.
      if (m_wr_en) pend[m_wr_reg] = 0;
      if (rsv_en && rsv_reg != 0) pend[rsv_reg] = 1;
      w_reg  = ea ? a_reg : b_reg;
      w_data = ea ? a_data : b_data;
      m_wr_en = (ea || eb) && w_reg != 0;
      if (m_wr_en) begin m_wr_reg = w_reg; m_wr_data = w_data; end
      if (ea || eb) m_last_b = eb;
      step();
      if (ea) a_req = 0;
      if (eb) b_req = 0;
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_single_write();
    test_alternate();
    test_busy();
    test_reg0();
    test_set_clear_same();
    test_forward();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
